// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM/owner enums and counter width for the memory port arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {MEM_ARB_IDLE, MEM_ARB_ISSUE, MEM_ARB_WAIT_RSP} mem_arb_state_t;
    typedef enum logic {MEM_ARB_OWNER_IC, MEM_ARB_OWNER_DC} mem_arb_owner_t;
    localparam int unsigned PERF_CNT_W = 32;
endpackage

// File: rtl/mem_port_arbiter_perf.sv
// mem_port_arb_perf: saturating grant/stall counters, used by mem_port_arbiter under MEM_PORT_ARB_PERF_EN.
module mem_port_arb_perf
    import mem_port_arbiter_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  ic_grant_i,
    input  logic                  dc_grant_i,
    input  logic                  stall_i,
    output logic [PERF_CNT_W-1:0] perf_ic_grants_o,
    output logic [PERF_CNT_W-1:0] perf_dc_grants_o,
    output logic [PERF_CNT_W-1:0] perf_mem_stall_o
);
    logic [PERF_CNT_W-1:0] ic_q, dc_q, st_q;
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ic_q <= '0;
            dc_q <= '0;
            st_q <= '0;
        end else begin
            ic_q <= ic_q + PERF_CNT_W'(ic_grant_i && !(&ic_q));
            dc_q <= dc_q + PERF_CNT_W'(dc_grant_i && !(&dc_q));
            st_q <= st_q + PERF_CNT_W'(stall_i && !(&st_q));
        end
    end
    assign perf_ic_grants_o = ic_q;
    assign perf_dc_grants_o = dc_q;
    assign perf_mem_stall_o = st_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between icache refills and dcache reads/writes.
// Define MEM_PORT_ARB_PERF_EN to add the perf_*_o counter ports.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  ic_req_valid_i,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
    output logic                  ic_req_ready_o,
    output logic                  ic_rsp_valid_o,
    output logic [LINE_WIDTH-1:0] ic_rsp_data_o,
    input  logic                  dc_req_valid_i,
    input  logic                  dc_req_we_i,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
    input  logic [LINE_WIDTH-1:0] dc_req_wdata_i,
    output logic                  dc_req_ready_o,
    output logic                  dc_rsp_valid_o,
    output logic [LINE_WIDTH-1:0] dc_rsp_data_o,
    output logic                  mem_req_valid_o,
    output logic                  mem_req_we_o,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [LINE_WIDTH-1:0] mem_req_wdata_o,
    input  logic                  mem_req_ready_i,
    input  logic                  mem_rsp_valid_i,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data_i,
    output logic                  busy_o
`ifdef MEM_PORT_ARB_PERF_EN
   ,output logic [PERF_CNT_W-1:0] perf_ic_grants_o,
    output logic [PERF_CNT_W-1:0] perf_dc_grants_o,
    output logic [PERF_CNT_W-1:0] perf_mem_stall_o
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    mem_arb_state_t        state_q;
    mem_arb_owner_t        owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  idle, ic_grant, dc_grant, rsp;

    // Grants are gated by reset_ni so ready stays low while reset is held.
    assign idle     = state_q == MEM_ARB_IDLE;
    assign ic_grant = reset_ni && idle && ic_req_valid_i && (starve_q == STARVE_MAX || !dc_req_valid_i);
    assign dc_grant = reset_ni && idle && dc_req_valid_i && !ic_grant;
    assign rsp      = state_q == MEM_ARB_WAIT_RSP && mem_rsp_valid_i;

    always_comb begin
        starve_d = ic_grant                    ? '0 :
                   dc_grant && ic_req_valid_i  ? (starve_q == STARVE_MAX ? starve_q : starve_q + SW'(1)) :
                   idle && !ic_req_valid_i     ? '0 : starve_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= MEM_ARB_IDLE;
            owner_q  <= MEM_ARB_OWNER_IC;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                MEM_ARB_IDLE: if (ic_grant || dc_grant) begin
                    state_q <= MEM_ARB_ISSUE;
                    owner_q <= dc_grant ? MEM_ARB_OWNER_DC : MEM_ARB_OWNER_IC;
                    addr_q  <= dc_grant ? dc_req_addr_i : ic_req_addr_i;
                    we_q    <= dc_grant && dc_req_we_i;
                    wdata_q <= dc_grant ? dc_req_wdata_i : '0;
                end
                MEM_ARB_ISSUE:    if (mem_req_ready_i) state_q <= MEM_ARB_WAIT_RSP;
                MEM_ARB_WAIT_RSP: if (mem_rsp_valid_i) state_q <= MEM_ARB_IDLE;
                default:          state_q <= MEM_ARB_IDLE;
            endcase
        end
    end

    assign ic_req_ready_o  = ic_grant;
    assign dc_req_ready_o  = dc_grant;
    assign ic_rsp_valid_o  = rsp && owner_q == MEM_ARB_OWNER_IC;
    assign dc_rsp_valid_o  = rsp && owner_q == MEM_ARB_OWNER_DC;
    assign ic_rsp_data_o   = mem_rsp_data_i;
    assign dc_rsp_data_o   = mem_rsp_data_i;
    assign mem_req_valid_o = state_q == MEM_ARB_ISSUE;
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wdata_o = wdata_q;
    assign busy_o          = !idle;

`ifdef MEM_PORT_ARB_PERF_EN
    mem_port_arb_perf u_perf (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .ic_grant_i       (ic_grant),
        .dc_grant_i       (dc_grant),
        .stall_i          (mem_req_valid_o && !mem_req_ready_i),
        .perf_ic_grants_o (perf_ic_grants_o),
        .perf_dc_grants_o (perf_dc_grants_o),
        .perf_mem_stall_o (perf_mem_stall_o)
    );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner cases and a random run against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW = 32, LW = 128, SL = 4;

    logic          clk_i = 1'b0, reset_ni = 1'b0;
    logic          ic_req_valid_i, ic_req_ready_o, ic_rsp_valid_o;
    logic [AW-1:0] ic_req_addr_i;
    logic [LW-1:0] ic_rsp_data_o;
    logic          dc_req_valid_i, dc_req_we_i, dc_req_ready_o, dc_rsp_valid_o;
    logic [AW-1:0] dc_req_addr_i;
    logic [LW-1:0] dc_req_wdata_i, dc_rsp_data_o;
    logic          mem_req_valid_o, mem_req_we_o, mem_req_ready_i, mem_rsp_valid_i, busy_o;
    logic [AW-1:0] mem_req_addr_o;
    logic [LW-1:0] mem_req_wdata_o, mem_rsp_data_i;
`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0]   perf_ic_grants_o, perf_dc_grants_o, perf_mem_stall_o;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(SL)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_data_o(ic_rsp_data_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_we_i(dc_req_we_i), .dc_req_addr_i(dc_req_addr_i),
        .dc_req_wdata_i(dc_req_wdata_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_data_o(dc_rsp_data_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i), .busy_o(busy_o)
`ifdef MEM_PORT_ARB_PERF_EN
       ,.perf_ic_grants_o(perf_ic_grants_o), .perf_dc_grants_o(perf_dc_grants_o),
        .perf_mem_stall_o(perf_mem_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0, checks = 0;

    // Reference model: the one outstanding transaction and whether memory has taken it.
    typedef struct { bit ic; logic [AW-1:0] addr; bit we; logic [LW-1:0] wdata; } txn_t;
    txn_t q[$];
    bit   m_acc;
    int   m_starve, m_icg, m_dcg, m_stall;
    int   glog[$];
    int   obs_ic, obs_dc;

    typedef struct { bit ic_v, dc_v, dc_we; logic [AW-1:0] ic_a, dc_a; bit e_ic, e_dc; logic [AW-1:0] e_addr; bit e_we; } vec_t;
    vec_t vt[4];

    task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic hard_reset();
        reset_ni = 1'b0;
        ic_req_valid_i = 0; ic_req_addr_i = '0;
        dc_req_valid_i = 0; dc_req_we_i = 0; dc_req_addr_i = '0; dc_req_wdata_i = '0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = '0;
        q.delete(); m_acc = 0; m_starve = 0; m_icg = 0; m_dcg = 0; m_stall = 0;
        glog.delete(); obs_ic = 0; obs_dc = 0;
        repeat (2) @(posedge clk_i);
        #1 reset_ni = 1'b1;
    endtask

    // One clock: compare at negedge against the model, then advance the model at posedge.
    task automatic cyc();
        bit idle, e_ic, e_dc, e_mv, e_rsp;
        txn_t t;
        @(negedge clk_i);
        idle  = q.size() == 0;
        t     = idle ? '{0, '0, 0, '0} : q[0];
        e_ic  = idle && ic_req_valid_i && (m_starve == SL || !dc_req_valid_i);
        e_dc  = idle && dc_req_valid_i && !e_ic;
        e_mv  = !idle && !m_acc;
        e_rsp = !idle && m_acc && mem_rsp_valid_i;
        chk("ic_ready", ic_req_ready_o, e_ic);
        chk("dc_ready", dc_req_ready_o, e_dc);
        chk("mem_valid", mem_req_valid_o, e_mv);
        if (e_mv) begin
            chk("mem_addr", mem_req_addr_o, t.addr);
            chk("mem_we", mem_req_we_o, t.we);
            chk("mem_wdata", mem_req_wdata_o, t.wdata);
        end
        chk("ic_rsp_valid", ic_rsp_valid_o, e_rsp && t.ic);
        chk("dc_rsp_valid", dc_rsp_valid_o, e_rsp && !t.ic);
        if (e_rsp && t.ic) chk("ic_rsp_data", ic_rsp_data_o, mem_rsp_data_i);
        if (e_rsp && !t.ic && !t.we) chk("dc_rsp_data", dc_rsp_data_o, mem_rsp_data_i);
        chk("busy", busy_o, !idle);
`ifdef MEM_PORT_ARB_PERF_EN
        chk("perf_ic", perf_ic_grants_o, m_icg);
        chk("perf_dc", perf_dc_grants_o, m_dcg);
        chk("perf_stall", perf_mem_stall_o, m_stall);
`endif
        if (ic_req_ready_o) glog.push_back(1);
        if (dc_req_ready_o) glog.push_back(0);
        obs_ic += int'(ic_rsp_valid_o);
        obs_dc += int'(dc_rsp_valid_o);
        m_icg += int'(e_ic);
        m_dcg += int'(e_dc);
        m_stall += int'(e_mv && !mem_req_ready_i);
        @(posedge clk_i);
        if (e_ic) begin
            q.push_back('{1, ic_req_addr_i, 0, '0});
            m_acc = 0; m_starve = 0;
        end else if (e_dc) begin
            q.push_back('{0, dc_req_addr_i, dc_req_we_i, dc_req_wdata_i});
            m_acc = 0;
            m_starve = ic_req_valid_i ? (m_starve < SL ? m_starve + 1 : SL) : 0;
        end else if (idle && !ic_req_valid_i) m_starve = 0;
        if (e_mv && mem_req_ready_i) m_acc = 1;
        else if (e_rsp) q.delete();
        #1;
    endtask

    initial begin
        vt[0] = '{0, 0, 0, 32'h100,  32'h200,  0, 0, 32'h0,    0};
        vt[1] = '{1, 0, 0, 32'h1000, 32'h2000, 1, 0, 32'h1000, 0};
        vt[2] = '{0, 1, 1, 32'h1000, 32'h2000, 0, 1, 32'h2000, 1};
        vt[3] = '{1, 1, 0, 32'h1040, 32'h2040, 0, 1, 32'h2040, 0};

        hard_reset();
        reset_ni = 1'b0;
        #3;
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_mem_we", mem_req_we_o, 0);
        chk("rst_ready", {ic_req_ready_o, dc_req_ready_o}, 0);
        chk("rst_rsp", {ic_rsp_valid_o, dc_rsp_valid_o}, 0);

        // Grant decision from a fresh IDLE with starve count 0.
        for (int i = 0; i < 4; i++) begin
            hard_reset();
            ic_req_valid_i = vt[i].ic_v; ic_req_addr_i = vt[i].ic_a;
            dc_req_valid_i = vt[i].dc_v; dc_req_addr_i = vt[i].dc_a; dc_req_we_i = vt[i].dc_we;
            dc_req_wdata_i = {4{32'h0BAD_F00D}};
            @(negedge clk_i);
            chk($sformatf("vec%0d_ic_ready", i), ic_req_ready_o, vt[i].e_ic);
            chk($sformatf("vec%0d_dc_ready", i), dc_req_ready_o, vt[i].e_dc);
            @(posedge clk_i);
            #1 ic_req_valid_i = 0; dc_req_valid_i = 0;
            @(negedge clk_i);
            chk($sformatf("vec%0d_mem_valid", i), mem_req_valid_o, vt[i].e_ic | vt[i].e_dc);
            if (vt[i].e_ic | vt[i].e_dc) begin
                chk($sformatf("vec%0d_addr", i), mem_req_addr_o, vt[i].e_addr);
                chk($sformatf("vec%0d_we", i), mem_req_we_o, vt[i].e_we);
            end
        end

        // Icache refill, memory ready at once, response two cycles after acceptance.
        hard_reset();
        ic_req_valid_i = 1; ic_req_addr_i = 32'h1000; mem_req_ready_i = 1;
        cyc();
        ic_req_valid_i = 0;
        cyc();
        cyc();
        mem_rsp_valid_i = 1; mem_rsp_data_i = {16{8'hA5}};
        cyc();
        mem_rsp_valid_i = 0;
        cyc();
        chk("ic_refill_pulses", obs_ic, 1);

        // Simultaneous requests: dcache first, icache right after the dcache response.
        hard_reset();
        ic_req_valid_i = 1; ic_req_addr_i = 32'h3000;
        dc_req_valid_i = 1; dc_req_addr_i = 32'h4000;
        mem_req_ready_i = 1; mem_rsp_valid_i = 1; mem_rsp_data_i = {4{32'h1234_5678}};
        for (int i = 0; i < 12 && glog.size() < 2; i++) begin
            cyc();
            if (glog.size() >= 1) dc_req_valid_i = 0;
        end
        ic_req_valid_i = 0;
        chk("tie_grants", glog.size(), 2);
        if (glog.size() == 2) chk("tie_order", {glog[0][0], glog[1][0]}, 2'b01);

        // Continuous dcache with icache waiting: four dcache grants per forced icache grant.
        hard_reset();
        ic_req_valid_i = 1; ic_req_addr_i = 32'h5000;
        dc_req_valid_i = 1; dc_req_addr_i = 32'h6000;
        mem_req_ready_i = 1; mem_rsp_valid_i = 1;
        for (int i = 0; i < 60 && glog.size() < 10; i++) cyc();
        chk("starve_grants", glog.size(), 10);
        for (int i = 0; i < glog.size(); i++)
            chk($sformatf("starve_g%0d", i), glog[i], (i % 5 == 4) ? 1 : 0);
        ic_req_valid_i = 0; dc_req_valid_i = 0;

        // Dcache write held off by memory for five cycles.
        hard_reset();
        dc_req_valid_i = 1; dc_req_we_i = 1; dc_req_addr_i = 32'h2000; dc_req_wdata_i = {4{32'hDEAD_BEEF}};
        cyc();
        dc_req_valid_i = 0;
        repeat (5) cyc();
        mem_req_ready_i = 1;
        cyc();
        mem_req_ready_i = 0;
        cyc();
        mem_rsp_valid_i = 1;
        cyc();
        mem_rsp_valid_i = 0;
        cyc();
        chk("write_ack_pulses", obs_dc, 1);
`ifdef MEM_PORT_ARB_PERF_EN
        chk("write_stall_cnt", perf_mem_stall_o, 5);
`endif

        // Reset during WAIT_RSP, then a stale response.
        hard_reset();
        ic_req_valid_i = 1; ic_req_addr_i = 32'h7000; mem_req_ready_i = 1;
        cyc();
        ic_req_valid_i = 0;
        cyc();
        chk("pre_reset_busy", busy_o, 1);
        reset_ni = 0;
        #1;
        chk("midrst_mem_valid", mem_req_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        q.delete(); m_acc = 0; m_starve = 0; m_icg = 0; m_dcg = 0; m_stall = 0; obs_ic = 0; obs_dc = 0;
        @(posedge clk_i);
        #1 reset_ni = 1;
        mem_rsp_valid_i = 1;
        cyc();
        mem_rsp_valid_i = 0;
        cyc();
        chk("stale_rsp_pulses", obs_ic + obs_dc, 0);

        // Responses injected in IDLE and ISSUE are ignored.
        hard_reset();
        mem_rsp_valid_i = 1; mem_rsp_data_i = {4{32'hFACE_CAFE}};
        repeat (2) cyc();
        dc_req_valid_i = 1; dc_req_addr_i = 32'h8000;
        cyc();
        dc_req_valid_i = 0;
        repeat (2) cyc();
        mem_req_ready_i = 1; mem_rsp_valid_i = 0;
        cyc();
        mem_req_ready_i = 0; mem_rsp_valid_i = 1;
        cyc();
        mem_rsp_valid_i = 0;
        cyc();
        chk("inject_pulses", obs_dc + obs_ic, 1);

        // Random traffic against the model.
        hard_reset();
        for (int i = 0; i < 3000; i++) begin
            ic_req_valid_i  = ($urandom % 4) != 0;
            ic_req_addr_i   = $urandom & 32'hFFFF_FFF0;
            dc_req_valid_i  = ($urandom % 4) != 0;
            dc_req_we_i     = $urandom % 2;
            dc_req_addr_i   = $urandom & 32'hFFFF_FFF0;
            dc_req_wdata_i  = {$urandom, $urandom, $urandom, $urandom};
            mem_req_ready_i = ($urandom % 3) != 0;
            mem_rsp_valid_i = ($urandom % 3) == 0;
            mem_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
